// File: rtl/fifo_ctrl.sv
// fifo_ctrl: first-word-fall-through FIFO controller for an external RAM with registered read data
`ifndef ADDR_FIFO
`define ADDR_FIFO 3
`endif
`ifndef WID_FIFO
`define WID_FIFO 8
`endif
`ifndef DEP_FIFO
`define DEP_FIFO (1 << `ADDR_FIFO)
`endif
module fifo_ctrl #(
  parameter int ADDR_W = `ADDR_FIFO,
  parameter int WIDTH = `WID_FIFO,
  parameter int AF_LEVEL = (1 << ADDR_W) - 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_valid,
  input  logic [WIDTH-1:0]  wr_data,
  output logic              wr_ready,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              almost_full,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [WIDTH-1:0]  mem_din,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [WIDTH-1:0]  mem_dout
);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] AF = (ADDR_W+1)'(AF_LEVEL);
  typedef enum logic {EMPTY, VALID} state_t;
  state_t state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [ADDR_W:0] mem_cnt_q, mem_cnt_d;
  logic pop;
  always_comb begin
    wr_ready = rst_n & !flush & (mem_cnt_q != FULL);
    mem_we = wr_valid & wr_ready;
    mem_waddr = wptr_q;
    mem_din = wr_data;
    rd_valid = state_q == VALID;
    rd_data = mem_dout;
    pop = rd_valid & rd_ready;
    mem_re = rst_n & !flush & (mem_cnt_q != '0) & (state_q == EMPTY | rd_ready);
    mem_raddr = rptr_q;
    count = mem_cnt_q + (ADDR_W+1)'(rd_valid);
    almost_full = count >= AF;
    wptr_d = flush ? '0 : wptr_q + ADDR_W'(mem_we);
    rptr_d = flush ? '0 : rptr_q + ADDR_W'(mem_re);
    mem_cnt_d = flush ? '0 : mem_cnt_q + (ADDR_W+1)'(mem_we) - (ADDR_W+1)'(mem_re);
    state_d = flush ? EMPTY : mem_re ? VALID : pop ? EMPTY : state_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      mem_cnt_q <= '0;
      state_q <= EMPTY;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      mem_cnt_q <= mem_cnt_d;
      state_q <= state_d;
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed self-checking bench for fifo_ctrl with a registered-read RAM model
module tb_fifo_ctrl;
  localparam int AW = 3;
  localparam int W = 8;
  localparam int DEPTH = 8;
  localparam int AF = 6;
  logic clk, rst_n, flush, wr_valid, wr_ready, rd_valid, rd_ready, almost_full;
  logic mem_we, mem_re;
  logic [W-1:0] wr_data, rd_data, mem_din, mem_dout;
  logic [AW:0] count;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [W-1:0] ram [DEPTH];
  int checks, failures;
  fifo_ctrl #(.ADDR_W(AW), .WIDTH(W), .AF_LEVEL(AF)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
    .count(count), .almost_full(almost_full),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_din(mem_din),
    .mem_re(mem_re), .mem_raddr(mem_raddr), .mem_dout(mem_dout)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_we) ram[mem_waddr] <= mem_din;
    if (mem_re) mem_dout <= ram[mem_raddr];
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 0; flush = 0; wr_valid = 1; wr_data = 8'h33; rd_ready = 0;
    @(negedge clk);
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL rst_count got %0d exp 0", count); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_rd_valid got %b exp 0", rd_valid); end
    checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL rst_af got %b exp 0", almost_full); end
    checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL rst_wr_ready got %b exp 0", wr_ready); end
    checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0) begin failures++; $display("FAIL rst_mem_en got we=%b re=%b exp 0 0", mem_we, mem_re); end
    tick;
    rst_n = 1; wr_valid = 0; rd_ready = 1;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL rel_wr_ready got %b exp 1", wr_ready); end
    tick;
    @(negedge clk);
    checks++; if (count !== 4'd0 || rd_valid !== 1'b0 || mem_re !== 1'b0) begin failures++; $display("FAIL idle_pop got count=%0d rv=%b re=%b exp 0 0 0", count, rd_valid, mem_re); end
    tick;
    rd_ready = 0;
  endtask
  task automatic test_single;
    wr_valid = 1; wr_data = 8'hA5;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_waddr !== 3'd0 || mem_din !== 8'hA5) begin failures++; $display("FAIL single_write got we=%b wa=%0d din=%h exp 1 0 a5", mem_we, mem_waddr, mem_din); end
    tick;
    wr_valid = 0;
    @(negedge clk);
    checks++; if (mem_re !== 1'b1 || mem_raddr !== 3'd0 || rd_valid !== 1'b0) begin failures++; $display("FAIL single_read got re=%b ra=%0d rv=%b exp 1 0 0", mem_re, mem_raddr, rd_valid); end
    tick;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5 || count !== 4'd1) begin failures++; $display("FAIL single_out got rv=%b data=%h count=%0d exp 1 a5 1", rd_valid, rd_data, count); end
    tick;
    rd_ready = 1;
    @(negedge clk);
    checks++; if (mem_re !== 1'b0 || rd_data !== 8'hA5) begin failures++; $display("FAIL single_pop got re=%b data=%h exp 0 a5", mem_re, rd_data); end
    tick;
    rd_ready = 0;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b0 || count !== 4'd0) begin failures++; $display("FAIL single_empty got rv=%b count=%0d exp 0 0", rd_valid, count); end
    tick;
  endtask
  task automatic test_fill;
    int acc, n, exp_cnt;
    acc = 0; n = 0; rd_ready = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      wr_valid = 1; wr_data = 8'(8'h10 + i);
      @(negedge clk);
      exp_cnt = (i < DEPTH + 1) ? i : DEPTH + 1;
      checks++; if (count !== 4'(exp_cnt)) begin failures++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, exp_cnt); end
      checks++; if (almost_full !== (exp_cnt >= AF)) begin failures++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, exp_cnt >= AF); end
      checks++; if (wr_ready !== (i < DEPTH + 1)) begin failures++; $display("FAIL fill_wr_ready[%0d] got %b exp %b", i, wr_ready, i < DEPTH + 1); end
      if (wr_ready) acc++;
      tick;
    end
    wr_valid = 0;
    @(negedge clk);
    checks++; if (acc !== DEPTH + 1) begin failures++; $display("FAIL fill_accepted got %0d exp %0d", acc, DEPTH + 1); end
    checks++; if (count !== 4'd9 || wr_ready !== 1'b0 || almost_full !== 1'b1) begin failures++; $display("FAIL full_state got count=%0d wr=%b af=%b exp 9 0 1", count, wr_ready, almost_full); end
    tick;
    rd_ready = 1;
    for (int c = 0; c < 30 && n < DEPTH + 1; c++) begin
      @(negedge clk);
      if (rd_valid) begin
        checks++; if (rd_data !== 8'(8'h10 + n)) begin failures++; $display("FAIL drain_data[%0d] got %h exp %h", n, rd_data, 8'(8'h10 + n)); end
        n++;
      end
      tick;
    end
    rd_ready = 0;
    @(negedge clk);
    checks++; if (n !== DEPTH + 1 || count !== 4'd0) begin failures++; $display("FAIL drain_total got n=%0d count=%0d exp 9 0", n, count); end
    tick;
  endtask
  task automatic test_stream;
    int sent, rcvd, first, bubbles;
    logic saw0;
    sent = 0; rcvd = 0; first = -1; bubbles = 0; saw0 = 0; rd_ready = 1;
    for (int c = 0; c < 3 * DEPTH + 10 && rcvd < 3 * DEPTH; c++) begin
      wr_valid = sent < 3 * DEPTH; wr_data = 8'(8'h40 + sent);
      @(negedge clk);
      if (mem_we && mem_waddr == 3'd0) saw0 = 1;
      if (rd_valid) begin
        if (first < 0) first = c;
        checks++; if (rd_data !== 8'(8'h40 + rcvd)) begin failures++; $display("FAIL stream_data[%0d] got %h exp %h", rcvd, rd_data, 8'(8'h40 + rcvd)); end
        rcvd++;
      end else if (first >= 0) bubbles++;
      if (wr_valid && wr_ready) sent++;
      tick;
    end
    wr_valid = 0; rd_ready = 0;
    @(negedge clk);
    checks++; if (first !== 2) begin failures++; $display("FAIL stream_latency got %0d exp 2", first); end
    checks++; if (bubbles !== 0) begin failures++; $display("FAIL stream_bubbles got %0d exp 0", bubbles); end
    checks++; if (rcvd !== 3 * DEPTH || count !== 4'd0) begin failures++; $display("FAIL stream_total got rcvd=%0d count=%0d exp 24 0", rcvd, count); end
    checks++; if (saw0 !== 1'b1) begin failures++; $display("FAIL stream_wrap got %b exp 1", saw0); end
    tick;
  endtask
  task automatic test_backpressure;
    int sent, rcvd;
    logic hold;
    logic [W-1:0] hold_data;
    sent = 0; rcvd = 0; hold = 0; hold_data = '0;
    for (int c = 0; c < 20000 && rcvd < 1000; c++) begin
      wr_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
      wr_data = 8'(sent);
      rd_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (hold) begin
        checks++; if (rd_valid !== 1'b1 || rd_data !== hold_data) begin failures++; $display("FAIL bp_hold got rv=%b data=%h exp 1 %h", rd_valid, rd_data, hold_data); end
      end
      if (rd_valid && rd_ready) begin
        checks++; if (rd_data !== 8'(rcvd)) begin failures++; $display("FAIL bp_data[%0d] got %h exp %h", rcvd, rd_data, 8'(rcvd)); end
        rcvd++;
      end
      if (wr_valid && wr_ready) sent++;
      hold = rd_valid && !rd_ready;
      hold_data = rd_data;
      tick;
    end
    wr_valid = 0; rd_ready = 0;
    @(negedge clk);
    checks++; if (rcvd !== 1000 || count !== 4'd0) begin failures++; $display("FAIL bp_total got rcvd=%0d count=%0d exp 1000 0", rcvd, count); end
    tick;
  endtask
  task automatic test_flush;
    rd_ready = 0;
    for (int i = 0; i < 5; i++) begin
      wr_valid = 1; wr_data = 8'(8'h60 + i);
      tick;
    end
    wr_data = 8'hEE; flush = 1; rd_ready = 1;
    @(negedge clk);
    checks++; if (count !== 4'd5 || rd_valid !== 1'b1) begin failures++; $display("FAIL flush_pre got count=%0d rv=%b exp 5 1", count, rd_valid); end
    checks++; if (mem_we !== 1'b0 || mem_re !== 1'b0 || wr_ready !== 1'b0) begin failures++; $display("FAIL flush_force got we=%b re=%b wr=%b exp 0 0 0", mem_we, mem_re, wr_ready); end
    tick;
    flush = 0; wr_valid = 0; rd_ready = 0;
    @(negedge clk);
    checks++; if (count !== 4'd0 || rd_valid !== 1'b0 || wr_ready !== 1'b1) begin failures++; $display("FAIL flush_post got count=%0d rv=%b wr=%b exp 0 0 1", count, rd_valid, wr_ready); end
    tick;
    wr_valid = 1; wr_data = 8'h77;
    @(negedge clk);
    checks++; if (mem_we !== 1'b1 || mem_waddr !== 3'd0) begin failures++; $display("FAIL flush_waddr got we=%b wa=%0d exp 1 0", mem_we, mem_waddr); end
    tick;
    wr_valid = 0;
    tick;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h77 || count !== 4'd1) begin failures++; $display("FAIL flush_next got rv=%b data=%h count=%0d exp 1 77 1", rd_valid, rd_data, count); end
    rd_ready = 1;
    tick;
    rd_ready = 0;
  endtask
  task automatic test_reset_mid;
    rd_ready = 1;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1; wr_data = 8'(8'h80 + i);
      tick;
    end
    checks++; if (count !== 4'd2 || rd_valid !== 1'b1) begin failures++; $display("FAIL mid_pre got count=%0d rv=%b exp 2 1", count, rd_valid); end
    rst_n = 0;
    #1;
    checks++; if (count !== 4'd0 || rd_valid !== 1'b0) begin failures++; $display("FAIL mid_async got count=%0d rv=%b exp 0 0", count, rd_valid); end
    checks++; if (wr_ready !== 1'b0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin failures++; $display("FAIL mid_outputs got wr=%b we=%b re=%b exp 0 0 0", wr_ready, mem_we, mem_re); end
    tick;
    tick;
    rst_n = 1; wr_data = 8'h99;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b1 || mem_we !== 1'b1 || mem_waddr !== 3'd0) begin failures++; $display("FAIL mid_first_write got wr=%b we=%b wa=%0d exp 1 1 0", wr_ready, mem_we, mem_waddr); end
    tick;
    wr_valid = 0;
    tick;
    @(negedge clk);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h99 || count !== 4'd1) begin failures++; $display("FAIL mid_out got rv=%b data=%h count=%0d exp 1 99 1", rd_valid, rd_data, count); end
    tick;
    rd_ready = 0;
    @(negedge clk);
    checks++; if (count !== 4'd0) begin failures++; $display("FAIL mid_final got count=%0d exp 0", count); end
  endtask
  initial begin
    checks = 0; failures = 0;
    test_reset;
    test_single;
    test_fill;
    test_stream;
    test_backpressure;
    test_flush;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default `ADDR_FIFO, RAM address width; DEPTH = 2^ADDR_W entries (= `DEP_FIFO).
REQ-002 The block SHALL have parameter WIDTH, default `WID_FIFO, data word width.
REQ-003 The block SHALL have parameter AF_LEVEL, default DEPTH-2, almost-full threshold on count.
REQ-004 The block SHALL have the following ports, clock and reset first:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all FIFO state.
- wr_valid  in  1  producer has a word.
- wr_data  in  WIDTH  producer word.
- wr_ready  out  1  word accepted when wr_valid & wr_ready.
- rd_valid  out  1  rd_data holds the head word.
- rd_data  out  WIDTH  head word, first-word-fall-through.
- rd_ready  in  1  consumer pops when rd_valid & rd_ready.
- count  out  ADDR_W+1  words held (RAM + output stage).
- almost_full  out  1  count >= AF_LEVEL.
- mem_we  out  1  RAM write enable.
- mem_waddr  out  ADDR_W  RAM write address.
- mem_din  out  WIDTH  RAM write data.
- mem_re  out  1  RAM read enable.
- mem_raddr  out  ADDR_W  RAM read address.
- mem_dout  in  WIDTH  RAM registered read data, valid the cycle after mem_re.

Function
REQ-005 The block SHALL hold the registers wptr, rptr (ADDR_W bits, wrapping modulo DEPTH), mem_cnt (0..DEPTH) and out_valid.
REQ-006 The block SHALL drive wr_ready = !flush & (mem_cnt != DEPTH), decoded from registered state only; a pop in the same cycle SHALL NOT raise wr_ready.
REQ-007 On a write (wr_valid & wr_ready), the block SHALL assert mem_we=1, mem_waddr=wptr and mem_din=wr_data combinationally, and SHALL increment wptr.
REQ-008 The output stage SHALL be a 2-state FSM: EMPTY (out_valid=0) and VALID (out_valid=1).
REQ-009 The block SHALL assert mem_re=1 with mem_raddr=rptr iff !flush & mem_cnt!=0 & (state==EMPTY | rd_ready); each such read SHALL increment rptr.
REQ-010 The FSM SHALL go EMPTY->VALID on mem_re; it SHALL go VALID->EMPTY on a pop without mem_re; it SHALL stay VALID on a pop with mem_re (back-to-back stream).
REQ-011 The block SHALL drive rd_valid = out_valid and rd_data = mem_dout; while in VALID with no pop, mem_re SHALL stay 0 so that mem_dout holds.
REQ-012 mem_cnt SHALL update as mem_cnt + write - mem_re; a simultaneous write and read SHALL leave it unchanged.
REQ-013 The block SHALL drive count = mem_cnt + out_valid; the maximum value SHALL be DEPTH+1.
REQ-014 Latency: a word written at edge N with the FIFO empty SHALL raise mem_re in cycle N+1 and rd_valid in cycle N+2.
REQ-015 With mem_cnt==0, a write and a pop in the same cycle SHALL empty the output stage; the new word SHALL follow per REQ-014.
REQ-016 A write with wr_ready=0 SHALL be ignored, with no state change; rd_ready with rd_valid=0 SHALL be ignored.
REQ-017 When flush=1, the block SHALL set wptr=rptr=0, mem_cnt=0 and state=EMPTY at the next edge, and SHALL force mem_we=mem_re=0 in that cycle.
REQ-018 The block SHALL NOT reset or initialise RAM contents; rd_data is don't-care while rd_valid=0.

Reset
REQ-019 While rst_n=0, the block SHALL asynchronously clear wptr, rptr, mem_cnt and state=EMPTY, giving rd_valid=0, count=0, almost_full=0 and wr_ready=0 (mem_cnt!=DEPTH only after release); mem_we and mem_re SHALL be 0.
REQ-020 Reset asserted mid-transfer SHALL discard all words; the first write after release SHALL go to address 0.
REQ-021 After rst_n deasserts, wr_ready SHALL be 1 in the first cycle.

Verification
REQ-022 The bench SHALL cover a single word: write 0xA5 at cycle 0 -> mem_re at cycle 1 with raddr=0, rd_valid=1 with rd_data=0xA5 at cycle 2, count=1.
REQ-023 The bench SHALL cover fill to full: DEPTH+2 writes with rd_ready=0 -> DEPTH+1 accepted, wr_ready=0 with count=DEPTH+1, almost_full=1 from count=AF_LEVEL.
REQ-024 The bench SHALL cover streaming: continuous writes and rd_ready=1 for 3*DEPTH words -> in-order data, pointers wrap through 0, no bubble after the first output.
REQ-025 The bench SHALL cover backpressure: rd_ready toggles 1/0 randomly -> rd_data stable while rd_valid & !rd_ready, and no loss or duplication across 1000 words.
REQ-026 The bench SHALL cover flush and reset: flush with count=5 -> count=0, rd_valid=0 next cycle; rst_n pulse mid-stream -> count=0 asynchronously, and the next write uses waddr=0.
